// File: rtl/tail_light_pkg.sv
// Shared types and lamp patterns for the rear-lamp sequencer.
package tail_light_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE   = 3'd0,
        MODE_LEFT   = 3'd1,
        MODE_RIGHT  = 3'd2,
        MODE_HAZARD = 3'd3,
        MODE_ERROR  = 3'd4
    } mode_t;

    localparam logic [2:0] CHASE_0   = 3'b000;
    localparam logic [2:0] CHASE_1   = 3'b001;
    localparam logic [2:0] CHASE_2   = 3'b011;
    localparam logic [2:0] CHASE_3   = 3'b111;
    localparam logic [2:0] LAMPS_ON  = 3'b111;
    localparam logic [2:0] LAMPS_OFF = 3'b000;

    // Turn-signal chase: lamps fill outward from the innermost (bit0).
    function automatic logic [2:0] chase(input logic [1:0] phase);
        logic [2:0] pat;
        case (phase)
            2'd0:    pat = CHASE_0;
            2'd1:    pat = CHASE_1;
            2'd2:    pat = CHASE_2;
            default: pat = CHASE_3;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock-enable generator: one-cycle tick every TICK_DIV clocks.
module tick_divider #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/tail_light_controller.sv
// Rear-lamp sequencer: arbitrates turn/hazard/brake requests into a lamp mode
// and steps the turn chase on a clock-enable tick.
module tail_light_controller
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
    input  logic       brake_req,
    output logic [2:0] left_lights,
    output logic [2:0] right_lights,
    output logic [1:0] center_lights,
    output logic       error_out,
    output logic       heartbeat
);

    // Request bit order: {hazard, brake, right, left}
    logic [3:0] req_s1;
    logic [3:0] req_s2;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            req_s1 <= '0;
            req_s2 <= '0;
        end else begin
            req_s1 <= {hazard_req, brake_req, right_req, left_req};
            req_s2 <= req_s1;
        end
    end

    logic left_s, right_s, brk, hazard_s;
    assign left_s   = req_s2[0];
    assign right_s  = req_s2[1];
    assign brk      = req_s2[2];
    assign hazard_s = req_s2[3];

    logic tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .tick     (tick)
    );

    mode_t      req_mode;
    mode_t      mode, mode_nxt;
    logic [1:0] phase, phase_nxt;

    always_comb begin
        req_mode = MODE_IDLE;
        if (hazard_s)               req_mode = MODE_HAZARD;
        else if (left_s && right_s) req_mode = MODE_ERROR;
        else if (left_s)            req_mode = MODE_LEFT;
        else if (right_s)           req_mode = MODE_RIGHT;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            mode  <= MODE_IDLE;
            phase <= 2'd0;
        end else begin
            mode  <= mode_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        mode_nxt  = mode;
        phase_nxt = phase;
        if (tick) begin
            if (req_mode != mode) begin
                mode_nxt  = req_mode;
                phase_nxt = (req_mode == MODE_IDLE || req_mode == MODE_ERROR) ? 2'd0 : 2'd1;
            end else if (mode == MODE_LEFT || mode == MODE_RIGHT || mode == MODE_HAZARD) begin
                phase_nxt = phase + 2'd1;
            end else begin
                phase_nxt = 2'd0;
            end
        end
    end

    // Lamps are decoded from next-cycle mode/phase so they land with the state update;
    // brake uses the current synchronized value and is not tick-gated.
    logic [2:0] left_nxt, right_nxt;
    logic       err_nxt;
    logic [2:0] brk_pat;

    assign brk_pat = brk ? LAMPS_ON : LAMPS_OFF;

    always_comb begin
        left_nxt  = brk_pat;
        right_nxt = brk_pat;
        err_nxt   = 1'b0;
        case (mode_nxt)
            MODE_LEFT:   left_nxt  = chase(phase_nxt);
            MODE_RIGHT:  right_nxt = chase(phase_nxt);
            MODE_HAZARD: begin
                left_nxt  = phase_nxt[0] ? LAMPS_ON : LAMPS_OFF;
                right_nxt = phase_nxt[0] ? LAMPS_ON : LAMPS_OFF;
            end
            MODE_ERROR: begin
                left_nxt  = LAMPS_OFF;
                right_nxt = LAMPS_OFF;
                err_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            left_lights   <= LAMPS_OFF;
            right_lights  <= LAMPS_OFF;
            center_lights <= 2'b00;
            error_out     <= 1'b0;
            heartbeat     <= 1'b0;
        end else begin
            left_lights   <= left_nxt;
            right_lights  <= right_nxt;
            center_lights <= {brk, brk};
            error_out     <= err_nxt;
            heartbeat     <= heartbeat ^ tick;
        end
    end

endmodule

// File: tb/tb_tail_light_controller.sv
// Directed bench for tail_light_controller with a 4-cycle tick.
module tb_tail_light_controller;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       left_req, right_req, hazard_req, brake_req;
    logic [2:0] left_lights, right_lights;
    logic [1:0] center_lights;
    logic       error_out, heartbeat;

    int n_vec = 0;
    int n_err = 0;
    logic hb_exp = 1'b0;

    tail_light_controller #(.TICK_DIV(4), .CNT_W(3)) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET_N       (RESET_N),
        .left_req      (left_req),
        .right_req     (right_req),
        .hazard_req    (hazard_req),
        .brake_req     (brake_req),
        .left_lights   (left_lights),
        .right_lights  (right_lights),
        .center_lights (center_lights),
        .error_out     (error_out),
        .heartbeat     (heartbeat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Clock n rising edges, then park on the falling edge for sampling/driving.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic tick_wait();
        step(4);
        hb_exp = ~hb_exp;
        chk("heartbeat", heartbeat, hb_exp);
    endtask

    task automatic lamps(input string tag, input logic [2:0] l, input logic [2:0] r,
                         input logic [1:0] c, input logic e);
        chk({tag, ".left"},   left_lights,   l);
        chk({tag, ".right"},  right_lights,  r);
        chk({tag, ".center"}, center_lights, c);
        chk({tag, ".error"},  error_out,     e);
    endtask

    initial begin
        // Reset with every request asserted
        RESET_N = 1'b0;
        left_req = 1'b1; right_req = 1'b1; hazard_req = 1'b1; brake_req = 1'b1;
        step(3);
        lamps("reset", 3'b000, 3'b000, 2'b00, 1'b0);
        chk("reset.hb", heartbeat, 1'b0);

        left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake_req = 1'b0;
        RESET_N = 1'b1;
        step(3);
        chk("pre_tick.hb", heartbeat, 1'b0);
        step(1);
        hb_exp = 1'b1;
        chk("first_tick.hb", heartbeat, 1'b1);
        lamps("idle", 3'b000, 3'b000, 2'b00, 1'b0);

        // Left chase
        left_req = 1'b1;
        tick_wait(); lamps("left1", 3'b001, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("left2", 3'b011, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("left3", 3'b111, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("left0", 3'b000, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("left1b", 3'b001, 3'b000, 2'b00, 1'b0);

        // Left+right conflict
        right_req = 1'b1;
        tick_wait(); lamps("conflict", 3'b000, 3'b000, 2'b00, 1'b1);
        right_req = 1'b0;
        tick_wait(); lamps("conflict_clr", 3'b001, 3'b000, 2'b00, 1'b0);

        // Hazard overrides left
        hazard_req = 1'b1;
        tick_wait(); lamps("haz1", 3'b111, 3'b111, 2'b00, 1'b0);
        tick_wait(); lamps("haz2", 3'b000, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("haz3", 3'b111, 3'b111, 2'b00, 1'b0);
        tick_wait(); lamps("haz0", 3'b000, 3'b000, 2'b00, 1'b0);

        // Right chase with brake overlay
        hazard_req = 1'b0; left_req = 1'b0; right_req = 1'b1;
        tick_wait(); lamps("right1", 3'b000, 3'b001, 2'b00, 1'b0);
        brake_req = 1'b1;
        step(2);      lamps("brk_sync", 3'b000, 3'b001, 2'b00, 1'b0);
        step(1);      lamps("brk_on", 3'b111, 3'b001, 2'b11, 1'b0);
        step(1);
        hb_exp = ~hb_exp;
        chk("heartbeat", heartbeat, hb_exp);
        lamps("right2_brk", 3'b111, 3'b011, 2'b11, 1'b0);

        // Idle with brake
        right_req = 1'b0;
        tick_wait(); lamps("idle_brk", 3'b111, 3'b111, 2'b11, 1'b0);
        brake_req = 1'b0;
        tick_wait(); lamps("idle_nobrk", 3'b000, 3'b000, 2'b00, 1'b0);

        // Reset in the middle of a left chase
        left_req = 1'b1;
        tick_wait(); lamps("pre_rst1", 3'b001, 3'b000, 2'b00, 1'b0);
        tick_wait(); lamps("pre_rst2", 3'b011, 3'b000, 2'b00, 1'b0);
        RESET_N = 1'b0;
        step(1);
        lamps("mid_rst", 3'b000, 3'b000, 2'b00, 1'b0);
        chk("mid_rst.hb", heartbeat, 1'b0);
        RESET_N = 1'b1;
        step(3);
        lamps("post_rst", 3'b000, 3'b000, 2'b00, 1'b0);
        step(1);
        hb_exp = 1'b1;
        chk("post_rst.hb", heartbeat, 1'b1);
        lamps("restart", 3'b001, 3'b000, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
